clk_measure: RTL
================

# clk_measure

Clock/pulse period meter that measures an external, asynchronous square wave (typically the output of the team's clock divider, or an off-board reference) in units of the local `clk_in`. It counts `clk_in` cycles between consecutive rising edges and, optionally, the cycles the input is high. Each completed period is published with a one-cycle `valid` strobe. A missing input is flagged with a `timeout` level. It sits on the FPGA test path as the checker for generated clocks.

## Interface
Parameters:
- `WIDE`, 24, width of the counters and the `period`/`high_time` outputs.
- `TIMEOUT`, 24'd1600_0000, cycles without a detected rising edge before `timeout` asserts. Must be ≥ 2 and ≤ 2^WIDE−1.

Ports:
- `clk_in`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `sig_in`  input  1  signal under measurement; asynchronous to `clk_in`.
- `period`  output  WIDE  last measured period in `clk_in` cycles.
- `high_time`  output  WIDE  last measured high width in `clk_in` cycles.
- `valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  output  1  level; no rising edge was seen within `TIMEOUT` cycles.

## Operation
- **Input conditioning.** `sig_in` passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`. Rise detect is `rise = s2 & ~s3`.
- **Counters.**
  - `cnt` counts cycles since the last rise, including the rise cycle.
  - `hi_cnt` counts cycles with `s2 = 1` since the last rise.
  - Both saturate: `cnt` at `TIMEOUT`, `hi_cnt` at `TIMEOUT`. Neither ever wraps.
- **State IDLE** (reset state): measurement is not yet armed.
  - `cnt` increments (saturating).
  - On `rise`: `cnt`←1, `hi_cnt`←1, `timeout`←0, go to RUN. No `valid` is issued.
- **State RUN**:
  - `cnt` increments every cycle. `hi_cnt` increments when `s2 = 1`.
  - On `rise`: `period`←`cnt`, `high_time`←`hi_cnt`, `valid`←1 for one cycle, `cnt`←1, `hi_cnt`←1. Stay in RUN.
  - If `cnt == TIMEOUT` with no `rise`: `timeout`←1, `period`←0, `high_time`←0, go to IDLE. No `valid` is issued.
- **Simultaneous events.** If `rise` and `cnt == TIMEOUT` occur in the same cycle, `rise` wins: the measurement is published (value = `TIMEOUT`) and `timeout` stays 0.
- **Resulting widths.** For an input of period P and high width H (in `clk_in` cycles, stable), `period` = P and `high_time` = H.
- **Input frequency limit.** Inputs with P < 2, or with high or low phases shorter than 1 cycle, are not supported; the results alias.
- **Reset.** On `rst` low, at any time:
  - all counters, outputs and synchronizer flops go to 0; state goes to IDLE.
  - A measurement in progress is discarded.

## Timing
- **Reset values:** `period`=0, `high_time`=0, `valid`=0, `timeout`=0.
- **Input to valid:** a `sig_in` rise set up before edge k gives `valid`=1 in the cycle after edge k+2 (3-edge latency).
- **Output update:** `period`/`high_time` change on the same edge that raises `valid`, then hold until the next publish, timeout, or reset.
- **valid:** never high for two consecutive cycles.
- **timeout:** asserts on the edge after `cnt` reaches `TIMEOUT`. It deasserts on the edge that registers the next `rise`.

## Configuration
- **`CLK_MEASURE_DUTY_EN` defined:** `hi_cnt` is implemented and `high_time` behaves as described above.
- **`CLK_MEASURE_DUTY_EN` undefined:**
  - `hi_cnt` is not built; `high_time` is tied to 0.
  - The port list is unchanged; `period`, `valid` and `timeout` are unaffected.

## Structure
- **Package `clk_measure_pkg`:**
  - state encoding (IDLE = 1'b0, RUN = 1'b1);
  - default `WIDE`;
  - default `TIMEOUT`.
- **Sub-module `clk_measure_sync`:** the 2-flop synchronizer, history flop and rise detector.
  - Ports: `clk_in`, `rst`, `d`, `q`, `rise`.
  - Reused by other asynchronous-input blocks.

## Test plan
- **Steady square wave:** `sig_in` period 10, high 4, for 5 periods → first rise gives no `valid`; then one `valid` per period with `period`=10, `high_time`=4; `timeout`=0 throughout.
- **Divider loopback:** clock divider with divide constant 24 drives `sig_in` → `period`=25, `high_time`=11 on every `valid` after the first.
- **Timeout and recovery:** `TIMEOUT`=100; stop `sig_in` low after a rise.
  - Expect: `timeout`=1 exactly 101 cycles after that rise was registered, `period`=`high_time`=0, no `valid`.
  - Then restart `sig_in`: the first rise clears `timeout` with no `valid`; the second rise gives a correct `valid`.
- **Minimum period:** `sig_in` toggles every `clk_in` cycle (P=2, H=1) → `valid` every 2 cycles, `period`=2, `high_time`=1.
- **Reset mid-measurement:** assert `rst` for 3 cycles halfway through a period of 10 → all outputs 0 during reset.
  - After release: no `valid` on the first rise; correct values on the second rise.
- **Macro off:** rerun the steady square-wave case without `CLK_MEASURE_DUTY_EN` → `period`=10, `high_time`=0.

Source files
------------

// File: rtl/clk_measure_pkg.sv
// rtl/clk_measure_pkg.sv - state encoding and default sizing shared by the clk_measure slice
package clk_measure_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned              DEF_WIDE    = 24;
   localparam logic [DEF_WIDE-1:0]      DEF_TIMEOUT = 24'd16_000_000;

endpackage

// File: rtl/clk_measure_sync.sv
// rtl/clk_measure_sync.sv - 2-flop synchronizer with history flop and rising-edge detect
module clk_measure_sync (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign q    = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_measure.sv
// rtl/clk_measure.sv - period / high-time meter for an asynchronous square wave
// High-time measurement is built only when CLK_MEASURE_DUTY_EN is defined.
module clk_measure
   import clk_measure_pkg::*;
#(
   parameter int unsigned     WIDE    = DEF_WIDE,
   parameter logic [WIDE-1:0] TIMEOUT = WIDE'(DEF_TIMEOUT)
) (
   input  logic            clk_in,
   input  logic            rst,
   input  logic            sig_in,
   output logic [WIDE-1:0] period,
   output logic [WIDE-1:0] high_time,
   output logic            valid,
   output logic            timeout
);

   state_t          state;
   state_t          state_nxt;
   logic            sig_s;
   logic            rise;
   logic            at_limit;
   logic [WIDE-1:0] cnt;
   logic [WIDE-1:0] cnt_inc;
   logic [WIDE-1:0] cnt_nxt;
   logic [WIDE-1:0] period_nxt;
   logic            valid_nxt;
   logic            timeout_nxt;
   logic            restart;
   logic            drop;

   clk_measure_sync u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (sig_in),
      .q      (sig_s),
      .rise   (rise)
   );

   assign at_limit = (cnt == TIMEOUT);
   assign cnt_inc  = at_limit ? cnt : cnt + WIDE'(1);

   // A rise always takes priority over the timeout limit in the same cycle.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt_inc;
      period_nxt  = period;
      valid_nxt   = 1'b0;
      timeout_nxt = timeout;
      restart     = 1'b0;
      drop        = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               cnt_nxt     = WIDE'(1);
               timeout_nxt = 1'b0;
               restart     = 1'b1;
               state_nxt   = RUN;
            end
         end
         RUN: begin
            if (rise) begin
               period_nxt = cnt;
               valid_nxt  = 1'b1;
               cnt_nxt    = WIDE'(1);
               restart    = 1'b1;
            end else if (at_limit) begin
               timeout_nxt = 1'b1;
               period_nxt  = '0;
               drop        = 1'b1;
               state_nxt   = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         period  <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         period  <= period_nxt;
         valid   <= valid_nxt;
         timeout <= timeout_nxt;
      end
   end

`ifdef CLK_MEASURE_DUTY_EN
   logic [WIDE-1:0] hi_cnt;
   logic [WIDE-1:0] hi_nxt;
   logic [WIDE-1:0] high_nxt;

   // The rise cycle itself is the first high cycle, hence the reload to 1.
   always_comb begin
      hi_nxt   = hi_cnt;
      high_nxt = high_time;
      if (restart) begin
         hi_nxt = WIDE'(1);
      end else if (state == RUN && sig_s && hi_cnt != TIMEOUT) begin
         hi_nxt = hi_cnt + WIDE'(1);
      end
      if (valid_nxt) begin
         high_nxt = hi_cnt;
      end else if (drop) begin
         high_nxt = '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         hi_cnt    <= '0;
         high_time <= '0;
      end else begin
         hi_cnt    <= hi_nxt;
         high_time <= high_nxt;
      end
   end
`else
   logic unused_duty;

   assign unused_duty = ^{sig_s, restart, drop};
   assign high_time   = '0;
`endif

endmodule
